// File: rtl/parking_lot_if.sv
// Gate sensor inputs and occupancy/event outputs of the parking lot counter.
// The sensor side drives a/b; the counter side drives count, flags and pulses.
interface parking_lot_if #(
    parameter int W = 8
);
    logic         a;
    logic         b;
    logic [W-1:0] count;
    logic         full;
    logic         empty;
    logic         enter;
    logic         exit;
    logic         err;
    logic         ovf;
    logic         unf;

    modport master (
        output a, b,
        input  count, full, empty, enter, exit, err, ovf, unf
    );

    modport slave (
        input  a, b,
        output count, full, empty, enter, exit, err, ovf, unf
    );
endinterface

// File: rtl/parking_lot_counter.sv
// Purpose: tracks cars through two gate beams and keeps a saturating occupancy count.
// Latency: count and event pulses are visible one cycle after the completing ab=00 sample.
// Backpressure: none; sensors are sampled every cycle and cannot be stalled.
module parking_lot_counter #(
    parameter int W   = 8,
    parameter int CAP = 200
) (
    input  logic         clk,
    input  logic         reset,
    parking_lot_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        E1   = 3'd1,
        E2   = 3'd2,
        E3   = 3'd3,
        X1   = 3'd4,
        X2   = 3'd5,
        X3   = 3'd6
    } state_t;

    localparam logic [W-1:0] CAP_W = W'(CAP);

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic         enter_q, enter_d;
    logic         exit_q,  exit_d;
    logic         err_q,   err_d;
    logic         ovf_q,   ovf_d;
    logic         unf_q,   unf_d;
    logic         entry_ev;
    logic         exit_ev;
    logic [1:0]   ab;

    assign ab = {bus.a, bus.b};

    always_comb begin
        state_d  = state_q;
        entry_ev = 1'b0;
        exit_ev  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = E1;
                    2'b01:   state_d = X1;
                    2'b11:   begin state_d = IDLE; err_d = 1'b1; end
                    default: state_d = IDLE;
                endcase
            end
            E1: begin
                case (ab)
                    2'b10:   state_d = E1;
                    2'b11:   state_d = E2;
                    2'b01:   begin state_d = IDLE; err_d = 1'b1; end
                    default: state_d = IDLE;
                endcase
            end
            E2: begin
                case (ab)
                    2'b11:   state_d = E2;
                    2'b01:   state_d = E3;
                    2'b10:   state_d = E1;
                    default: begin state_d = IDLE; err_d = 1'b1; end
                endcase
            end
            E3: begin
                case (ab)
                    2'b01:   state_d = E3;
                    2'b11:   state_d = E2;
                    2'b10:   begin state_d = IDLE; err_d = 1'b1; end
                    default: begin state_d = IDLE; entry_ev = 1'b1; end
                endcase
            end
            X1: begin
                case (ab)
                    2'b01:   state_d = X1;
                    2'b11:   state_d = X2;
                    2'b10:   begin state_d = IDLE; err_d = 1'b1; end
                    default: state_d = IDLE;
                endcase
            end
            X2: begin
                case (ab)
                    2'b11:   state_d = X2;
                    2'b10:   state_d = X3;
                    2'b01:   state_d = X1;
                    default: begin state_d = IDLE; err_d = 1'b1; end
                endcase
            end
            X3: begin
                case (ab)
                    2'b10:   state_d = X3;
                    2'b11:   state_d = X2;
                    2'b01:   begin state_d = IDLE; err_d = 1'b1; end
                    default: begin state_d = IDLE; exit_ev = 1'b1; end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Count saturates at both ends; a held count reports ovf/unf instead of enter/exit.
    always_comb begin
        count_d = count_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (entry_ev) begin
            if (count_q >= CAP_W) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
                enter_d = 1'b1;
            end
        end else if (exit_ev) begin
            if (count_q == '0) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - W'(1);
                exit_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.full  = (count_q == CAP_W);
    assign bus.empty = (count_q == '0);
    assign bus.enter = enter_q;
    assign bus.exit  = exit_q;
    assign bus.err   = err_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule
